// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multicycle RISC-V control path.
package riscv_mc_pkg;

   // Controller states
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      MEMADR  = 4'd3,
      MEM_RD  = 4'd4,
      MEM_WR  = 4'd5,
      LOAD_WB = 4'd6,
      EXEC_R  = 4'd7,
      EXEC_I  = 4'd8,
      ALU_WB  = 4'd9,
      BRANCH  = 4'd10,
      FAULT   = 4'd11
   } state_t;

   // Major opcodes (Instruction[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

   // ALU operation class handed to ALU_Control
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // Fault codes
   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   // States that hold a memory request open and wait on mem_ready
   function automatic logic is_mem_state(state_t s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

   // States whose exit to FETCH completes an instruction
   function automatic logic is_retire_state(state_t s);
      return (s == MEM_WR) || (s == LOAD_WB) || (s == ALU_WB) || (s == BRANCH);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled cycles of a memory access and flags
// a timeout on the last permitted stalled cycle.
module mem_wait_timer #(
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic waiting,
   input  logic mem_ready,
   output logic timeout
);

   localparam logic [7:0] LIMIT = 8'(MEM_WAIT_MAX - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: restart on state change, advance only while stalled
   always_comb begin
      count_d = count_q;
      if (clear || !waiting) begin
         count_d = '0;
      end else if (!mem_ready) begin
         count_d = count_q + 8'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A ready in the final cycle still completes the access
   assign timeout = waiting && !mem_ready && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing a multicycle RISC-V datapath over one shared
// memory port. Optional performance counters are enabled with MCTRL_PERF_EN.
module multicycle_control
   import riscv_mc_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        pc_src,
   output logic        fault,
   output logic [1:0]  fault_code
`ifdef MCTRL_PERF_EN
   ,
   output logic [63:0] cycle_count,
   output logic [63:0] instret_count
`endif
);

   state_t     state_q;
   state_t     state_d;
   logic [1:0] fault_code_q;
   logic [1:0] fault_set;
   logic       waiting;
   logic       clear;
   logic       timeout;

   assign waiting = is_mem_state(state_q);
   // Any state change restarts the wait count, covering re-entry into FETCH
   assign clear   = (state_d != state_q);

   mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX)
   ) u_mem_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .waiting   (waiting),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and fault cause on entry into FAULT
   always_comb begin
      state_d   = state_q;
      fault_set = FAULT_NONE;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (mem_ready) begin
               state_d = DECODE;
            end else if (timeout) begin
               state_d   = FAULT;
               fault_set = FAULT_TIMEOUT;
            end
         end
         DECODE: begin
            unique case (opcode)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXEC_R;
               OP_ITYPE:          state_d = EXEC_I;
               OP_BRANCH:         state_d = BRANCH;
               default: begin
                  state_d   = FAULT;
                  fault_set = FAULT_ILLEGAL;
               end
            endcase
         end
         MEMADR: state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (mem_ready) begin
               state_d = LOAD_WB;
            end else if (timeout) begin
               state_d   = FAULT;
               fault_set = FAULT_TIMEOUT;
            end
         end
         MEM_WR: begin
            if (mem_ready) begin
               state_d = FETCH;
            end else if (timeout) begin
               state_d   = FAULT;
               fault_set = FAULT_TIMEOUT;
            end
         end
         LOAD_WB:        state_d = FETCH;
         EXEC_R, EXEC_I: state_d = ALU_WB;
         ALU_WB:         state_d = FETCH;
         BRANCH:         state_d = FETCH;
         FAULT:          state_d = FAULT;
         default:        state_d = IDLE;
      endcase
   end

   // Fault cause register, captured once on entry into FAULT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_code_q <= FAULT_NONE;
      end else if (fault_set != FAULT_NONE) begin
         fault_code_q <= fault_set;
      end
   end

   // Output decode from the registered state
   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALU_OP_ADD;
      pc_src     = 1'b0;
      fault      = 1'b0;
      fault_code = FAULT_NONE;
      unique case (state_q)
         IDLE: ;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            // PC+4 and IR load only when the read data is actually present
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: alu_src_b = SRCB_IMM_SH1;
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         LOAD_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_FUNCT;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_OP_FUNCT;
         end
         ALU_WB: reg_write = 1'b1;
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_SUB;
            pc_src    = 1'b1;
            pc_write  = zero;
         end
         FAULT: begin
            fault      = 1'b1;
            fault_code = fault_code_q;
         end
         default: ;
      endcase
   end

`ifdef MCTRL_PERF_EN
   // Performance counters; both stop advancing once in FAULT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         if (state_q != IDLE && state_q != FAULT) begin
            cycle_count <= cycle_count + 64'd1;
         end
         if (state_d == FETCH && is_retire_state(state_q)) begin
            instret_count <= instret_count + 64'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. Outputs are packed
// into one 16-bit word and compared against hand-computed per-state vectors.
module tb_multicycle_control;

   logic        clk;
   logic        reset;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
   logic        mem_to_reg, alu_src_a, pc_src, fault;
   logic [1:0]  alu_src_b, alu_op, fault_code;
`ifdef MCTRL_PERF_EN
   logic [63:0] cycle_count, instret_count;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
   //  alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src, fault, fault_code[1:0]}
   logic [15:0] outs;
   assign outs = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, fault, fault_code};

   localparam logic [15:0] V_IDLE    = 16'h0000;
   localparam logic [15:0] V_FETCH   = 16'h1040;
   localparam logic [15:0] V_FETCH_R = 16'hD040;
   localparam logic [15:0] V_DECODE  = 16'h00C0;
   localparam logic [15:0] V_MEMADR  = 16'h0180;
   localparam logic [15:0] V_MEM_RD  = 16'h3000;
   localparam logic [15:0] V_MEM_WR  = 16'h2800;
   localparam logic [15:0] V_LOAD_WB = 16'h0600;
   localparam logic [15:0] V_EXEC_R  = 16'h0120;
   localparam logic [15:0] V_EXEC_I  = 16'h01A0;
   localparam logic [15:0] V_ALU_WB  = 16'h0400;
   localparam logic [15:0] V_BR_TK   = 16'h8118;
   localparam logic [15:0] V_BR_NT   = 16'h0118;
   localparam logic [15:0] V_F_ILL   = 16'h0005;
   localparam logic [15:0] V_F_TMO   = 16'h0006;

   multicycle_control #(
      .MEM_WAIT_MAX (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .fault      (fault),
      .fault_code (fault_code)
`ifdef MCTRL_PERF_EN
      ,
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after a negedge; each task's first cycle is IDLE
   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (outs !== V_IDLE) begin
         n_fails++; $display("FAIL reset_held: outs %h, want %h", outs, V_IDLE);
      end
      @(negedge clk); reset = 1'b0; #1;
      n_checks++;
      if (outs !== V_IDLE) begin
         n_fails++; $display("FAIL reset_release_idle: outs %h, want %h", outs, V_IDLE);
      end
      @(negedge clk); #1;
      n_checks++;
      if (outs !== V_FETCH) begin
         n_fails++; $display("FAIL reset_then_fetch: outs %h, want %h", outs, V_FETCH);
      end
   endtask

   task automatic test_rtype();
      logic [15:0] ex [6];
      ex = '{V_IDLE, V_FETCH_R, V_DECODE, V_EXEC_R, V_ALU_WB, V_FETCH_R};
      do_reset(); opcode = 7'b0110011; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1; n_checks++;
         if (outs !== ex[i]) begin
            n_fails++; $display("FAIL rtype[%0d]: outs %h, want %h", i, outs, ex[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_itype_store();
      logic [15:0] exi [6];
      logic [15:0] exs [6];
      exi = '{V_IDLE, V_FETCH_R, V_DECODE, V_EXEC_I, V_ALU_WB, V_FETCH_R};
      exs = '{V_IDLE, V_FETCH_R, V_DECODE, V_MEMADR, V_MEM_WR, V_FETCH_R};
      do_reset(); opcode = 7'b0010011; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1; n_checks++;
         if (outs !== exi[i]) begin
            n_fails++; $display("FAIL itype[%0d]: outs %h, want %h", i, outs, exi[i]);
         end
         @(negedge clk);
      end
      do_reset(); opcode = 7'b0100011; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1; n_checks++;
         if (outs !== exs[i]) begin
            n_fails++; $display("FAIL store[%0d]: outs %h, want %h", i, outs, exs[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load_wait();
      logic [15:0] ex  [10];
      logic        rdy [10];
      ex  = '{V_IDLE, V_FETCH_R, V_DECODE, V_MEMADR, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_RD,
              V_LOAD_WB, V_FETCH_R};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset(); opcode = 7'b0000011;
      for (int i = 0; i < 10; i++) begin
         mem_ready = rdy[i]; #1; n_checks++;
         if (outs !== ex[i]) begin
            n_fails++; $display("FAIL load_wait[%0d]: outs %h, want %h", i, outs, ex[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(); opcode = 7'b0000011; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (outs !== V_MEM_RD) begin
         n_fails++; $display("FAIL mid_in_mem_rd: outs %h, want %h", outs, V_MEM_RD);
      end
      reset = 1'b1; #1;
      n_checks++;
      if (outs !== V_IDLE) begin
         n_fails++; $display("FAIL mid_reset_same_cycle: outs %h, want %h", outs, V_IDLE);
      end
      @(negedge clk); reset = 1'b0; #1;
      n_checks++;
      if (outs !== V_IDLE) begin
         n_fails++; $display("FAIL mid_release_idle: outs %h, want %h", outs, V_IDLE);
      end
      @(negedge clk); #1;
      n_checks++;
      if (outs !== V_FETCH) begin
         n_fails++; $display("FAIL mid_then_fetch: outs %h, want %h", outs, V_FETCH);
      end
   endtask

   task automatic test_branch();
      logic [15:0] ex_tk [4];
      logic [15:0] ex_nt [4];
      ex_tk = '{V_IDLE, V_FETCH_R, V_DECODE, V_BR_TK};
      ex_nt = '{V_FETCH_R, V_DECODE, V_BR_NT, V_FETCH_R};
      do_reset(); opcode = 7'b1100011; mem_ready = 1'b1; zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1; n_checks++;
         if (outs !== ex_tk[i]) begin
            n_fails++; $display("FAIL branch_taken[%0d]: outs %h, want %h", i, outs, ex_tk[i]);
         end
         @(negedge clk);
      end
      zero = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1; n_checks++;
         if (outs !== ex_nt[i]) begin
            n_fails++; $display("FAIL branch_not[%0d]: outs %h, want %h", i, outs, ex_nt[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      do_reset(); opcode = 7'b0110011; mem_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         #1; n_checks++;
         if (outs !== V_FETCH) begin
            n_fails++; $display("FAIL tmo_fetch[%0d]: outs %h, want %h", i, outs, V_FETCH);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         mem_ready = i[0]; #1; n_checks++;
         if (outs !== V_F_TMO) begin
            n_fails++; $display("FAIL tmo_fault[%0d]: outs %h, want %h", i, outs, V_F_TMO);
         end
         @(negedge clk);
      end
      // Ready on the last permitted cycle must win over the timeout
      do_reset(); mem_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         #1; n_checks++;
         if (outs !== V_FETCH) begin
            n_fails++; $display("FAIL late_fetch[%0d]: outs %h, want %h", i, outs, V_FETCH);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1; #1;
      n_checks++;
      if (outs !== V_FETCH_R) begin
         n_fails++; $display("FAIL late_ready: outs %h, want %h", outs, V_FETCH_R);
      end
      @(negedge clk); #1;
      n_checks++;
      if (outs !== V_DECODE) begin
         n_fails++; $display("FAIL late_decode: outs %h, want %h", outs, V_DECODE);
      end
   endtask

   task automatic test_illegal();
      logic [15:0] ex [6];
      ex = '{V_IDLE, V_FETCH_R, V_DECODE, V_F_ILL, V_F_ILL, V_F_ILL};
      do_reset(); opcode = 7'b1111111; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         zero = i[0]; #1; n_checks++;
         if (outs !== ex[i]) begin
            n_fails++; $display("FAIL illegal[%0d]: outs %h, want %h", i, outs, ex[i]);
         end
         @(negedge clk);
      end
      reset = 1'b1; #1;
      n_checks++;
      if (outs !== V_IDLE) begin
         n_fails++; $display("FAIL illegal_reset: outs %h, want %h", outs, V_IDLE);
      end
      @(negedge clk); reset = 1'b0;
   endtask

`ifdef MCTRL_PERF_EN
   task automatic test_perf();
      do_reset(); opcode = 7'b0110011; mem_ready = 1'b1;
      #1; n_checks++;
      if (cycle_count !== 64'd0 || instret_count !== 64'd0) begin
         n_fails++;
         $display("FAIL perf_reset: cycle %0d instret %0d, want 0 0", cycle_count, instret_count);
      end
      repeat (13) @(negedge clk);
      #1; n_checks++;
      if (cycle_count !== 64'd12 || instret_count !== 64'd3) begin
         n_fails++;
         $display("FAIL perf_3_rtype: cycle %0d instret %0d, want 12 3",
                  cycle_count, instret_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_rtype();
      test_itype_store();
      test_load_wait();
      test_reset_mid();
      test_branch();
      test_timeout();
      test_illegal();
`ifdef MCTRL_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Safety net against a stalled run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
